pulse_train_gen: RTL

Generates a burst of N clean, debounced-style pulses on a single output line, for driving edge-triggered inputs such as the lab's 2-bit up counter from a control FSM or test fixture. On an accepted start request it latches a count, emits exactly that many high pulses with fixed high width and low gap, then signals completion. It sits upstream of any rising-edge-detecting consumer, supplying the pulses a push-button would otherwise provide.

---
 rtl/pulse_gen_pkg.sv | 17 +
 rtl/start_sync_edge.sv | 31 +++
 rtl/pulse_train_gen.sv | 118 +++++++++++
 3 files changed

// File: rtl/pulse_gen_pkg.sv
// Shared definitions for the pulse train generator.
//   state_e      : burst FSM states
//   DefHighCyc   : default pulse high width in clock cycles
//   DefLowCyc    : default low gap after each pulse in clock cycles
package pulse_gen_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHigh = 2'd1,
    StLow  = 2'd2,
    StDone = 2'd3
  } state_e;

  localparam int unsigned DefHighCyc = 2;
  localparam int unsigned DefLowCyc  = 2;

endpackage

// File: rtl/start_sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector.
// Produces a one-cycle strobe two edges after din is first sampled high;
// a held-high din yields a single strobe.
// Ports:
//   clk    : clock
//   rst    : asynchronous active-low reset
//   din    : asynchronous level input
//   strobe : one-cycle pulse on a synchronized rising edge
module start_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic strobe
);

  logic [1:0] sync_q;
  logic       prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], din};
      prev_q <= sync_q[1];
    end
  end

  assign strobe = sync_q[1] & ~prev_q;

endmodule

// File: rtl/pulse_train_gen.sv
// Pulse train generator: on an accepted start, latches n and emits exactly n
// pulses, each HIGH_CYC cycles high followed by LOW_CYC cycles low, then
// strobes done for one cycle.
// Build option: define PULSE_START_SYNC_EN to pass start through a two-flop
// synchronizer and rising-edge detector (one burst per start assertion,
// two extra cycles of accept latency). Otherwise start is a synchronous level.
// Ports:
//   clk   : clock, posedge
//   rst   : asynchronous active-low reset
//   start : burst request
//   n     : number of pulses to emit
//   x_out : pulse train (registered)
//   busy  : burst in progress (registered)
//   done  : one-cycle completion strobe (registered)
//   sent  : pulses fully emitted in current/most recent burst (registered)
module pulse_train_gen
  import pulse_gen_pkg::*;
#(
  parameter int unsigned CNT_W    = 2,
  parameter int unsigned HIGH_CYC = DefHighCyc,
  parameter int unsigned LOW_CYC  = DefLowCyc
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] n,
  output logic             x_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sent
);

  localparam int unsigned MaxCyc = (HIGH_CYC > LOW_CYC) ? HIGH_CYC : LOW_CYC;
  localparam int unsigned PhW    = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;
  localparam logic [PhW-1:0] HighLast = PhW'(HIGH_CYC - 1);
  localparam logic [PhW-1:0] LowLast  = PhW'(LOW_CYC - 1);

  logic             start_stb;
  state_e           state_q;
  logic [PhW-1:0]   phase_q;
  logic [CNT_W-1:0] n_q;
  logic [CNT_W-1:0] sent_inc;

`ifdef PULSE_START_SYNC_EN
  start_sync_edge u_start_sync (
    .clk    (clk),
    .rst    (rst),
    .din    (start),
    .strobe (start_stb)
  );
`else
  assign start_stb = start;
`endif

  // Cannot wrap: sent only advances while below the latched n.
  assign sent_inc = sent + CNT_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      phase_q <= '0;
      n_q     <= '0;
      sent    <= '0;
      x_out   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_stb) begin
            n_q     <= n;
            sent    <= '0;
            phase_q <= '0;
            if (n != '0) begin
              state_q <= StHigh;
              x_out   <= 1'b1;
              busy    <= 1'b1;
            end else begin
              state_q <= StDone;
              done    <= 1'b1;
            end
          end
        end
        StHigh: begin
          if (phase_q == HighLast) begin
            state_q <= StLow;
            phase_q <= '0;
            x_out   <= 1'b0;
          end else begin
            phase_q <= phase_q + PhW'(1);
          end
        end
        StLow: begin
          if (phase_q == LowLast) begin
            phase_q <= '0;
            sent    <= sent_inc;
            if (sent_inc == n_q) begin
              state_q <= StDone;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              state_q <= StHigh;
              x_out   <= 1'b1;
            end
          end else begin
            phase_q <= phase_q + PhW'(1);
          end
        end
        StDone: begin
          state_q <= StIdle;
          done    <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
